// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
// key_event_queue : classifies debounced key presses as SHORT, LONG or REPEAT
//                   and queues the events in a show-ahead FIFO.
// Revision        : 1.0
// ============================================================================
module key_event_queue #(
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          neg_tick,
   input  logic          pos_tick,
   input  logic [2:0]    kcode,
   input  logic          rd_en,
   input  logic          ovf_clr,
   output logic          ev_valid,
   output logic [2:0]    ev_code,
   output logic [1:0]    ev_type,
   output logic [AW:0]   ev_count,
   output logic          full,
   output logic          overflow
);

   localparam int HW = $clog2(LONG_CYC);
   localparam int RW = $clog2(REPEAT_CYC);

   localparam logic [1:0] c_idle    = 2'd0;
   localparam logic [1:0] c_pressed = 2'd1;
   localparam logic [1:0] c_held    = 2'd2;

   localparam logic [1:0] c_short  = 2'b00;
   localparam logic [1:0] c_long   = 2'b01;
   localparam logic [1:0] c_repeat = 2'b10;

   localparam logic [HW-1:0] c_hold_last = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] c_hold_one  = HW'(1);
   localparam logic [RW-1:0] c_rep_last  = RW'(REPEAT_CYC - 1);
   localparam logic [RW-1:0] c_rep_one   = RW'(1);
   localparam logic [AW-1:0] c_ptr_one   = AW'(1);
   localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
   localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);

   logic [1:0]    r_state;
   logic [2:0]    r_key;
   logic [HW-1:0] r_hold;
   logic [RW-1:0] r_rep;

   logic [2:0]    r_mem_code [DEPTH];
   logic [1:0]    r_mem_type [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [2:0]    r_head_code;
   logic [1:0]    r_head_type;

   logic          w_push_req;
   logic [1:0]    w_push_type;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic [AW-1:0] w_rd_next;

   // Release takes priority over a terminal count in both active states.
   always_comb begin
      w_push_req  = 1'b0;
      w_push_type = c_short;
      case (r_state)
         c_pressed: begin
            if (pos_tick) begin
               w_push_req  = 1'b1;
               w_push_type = c_short;
            end else if (r_hold == c_hold_last) begin
               w_push_req  = 1'b1;
               w_push_type = c_long;
            end
         end
         c_held: begin
            if (!pos_tick && (r_rep == c_rep_last)) begin
               w_push_req  = 1'b1;
               w_push_type = c_repeat;
            end
         end
         default: ;
      endcase
   end

   assign w_pop     = rd_en && (r_count != '0);
   assign w_full    = (r_count == c_depth);
   assign w_push    = w_push_req && (!w_full || w_pop);
   assign w_drop    = w_push_req && w_full && !w_pop;
   assign w_rd_next = r_rd_ptr + c_ptr_one;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_idle;
         r_key   <= '0;
         r_hold  <= '0;
         r_rep   <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (neg_tick) begin
                  r_key   <= kcode;
                  r_hold  <= '0;
                  r_state <= c_pressed;
               end
            end
            c_pressed: begin
               if (pos_tick) begin
                  r_state <= c_idle;
               end else if (r_hold == c_hold_last) begin
                  r_rep   <= '0;
                  r_state <= c_held;
               end else begin
                  r_hold <= r_hold + c_hold_one;
               end
            end
            c_held: begin
               if (pos_tick) begin
                  r_state <= c_idle;
               end else if (r_rep == c_rep_last) begin
                  r_rep <= '0;
               end else begin
                  r_rep <= r_rep + c_rep_one;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_code[r_wr_ptr] <= r_key;
         r_mem_type[r_wr_ptr] <= w_push_type;
      end
   end

   // The head is kept in its own register so the outputs hold the last
   // entry once the FIFO drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_head_code <= '0;
         r_head_type <= c_short;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: ;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_push && ((r_count == '0) || (w_pop && (r_count == c_cnt_one)))) begin
            r_head_code <= r_key;
            r_head_type <= w_push_type;
         end else if (w_pop && (r_count > c_cnt_one)) begin
            r_head_code <= r_mem_code[w_rd_next];
            r_head_type <= r_mem_type[w_rd_next];
         end
      end
   end

   assign ev_valid = (r_count != '0);
   assign ev_code  = r_head_code;
   assign ev_type  = r_head_type;
   assign ev_count = r_count;
   assign full     = w_full;
   assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_key_event_queue.sv
`default_nettype none
// tb_key_event_queue : randomized scoreboard bench for key_event_queue,
// with event timing derived from press durations.
module tb_key_event_queue;

   localparam int LONG_CYC   = 100;
   localparam int REPEAT_CYC = 20;
   localparam int DEPTH      = 4;
   localparam int AW         = 2;

   localparam logic [1:0] T_SHORT  = 2'b00;
   localparam logic [1:0] T_LONG   = 2'b01;
   localparam logic [1:0] T_REPEAT = 2'b10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          neg_tick = 1'b0;
   logic          pos_tick = 1'b0;
   logic [2:0]    kcode = 3'd0;
   logic          rd_en = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          ev_valid;
   logic [2:0]    ev_code;
   logic [1:0]    ev_type;
   logic [AW:0]   ev_count;
   logic          full;
   logic          overflow;

   key_event_queue #(
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .neg_tick (neg_tick),
      .pos_tick (pos_tick),
      .kcode    (kcode),
      .rd_en    (rd_en),
      .ovf_clr  (ovf_clr),
      .ev_valid (ev_valid),
      .ev_code  (ev_code),
      .ev_type  (ev_type),
      .ev_count (ev_count),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_no;
      logic [1:0] typ;
      logic [2:0] code;
   } sched_t;

   typedef struct packed {
      logic [1:0] typ;
      logic [2:0] code;
   } ev_t;

   sched_t pending[$];
   ev_t    exp_q[$];
   ev_t    last_ev = '0;
   bit     exp_ovf = 1'b0;
   int     edge_n = 0;
   int     checks = 0;
   int     failures = 0;
   bit     rand_mode = 1'b0;

   // Reference: the expected FIFO contents, updated on every clock edge.
   always @(posedge clk) begin : model_step
      bit  pop;
      bit  have;
      bit  dropped;
      ev_t nev;
      edge_n++;
      if (!reset) begin
         exp_q.delete();
         pending.delete();
         last_ev = '0;
         exp_ovf = 1'b0;
      end else begin
         pop     = rd_en && (exp_q.size() > 0);
         have    = 1'b0;
         dropped = 1'b0;
         nev     = '0;
         for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].edge_no == edge_n) begin
               have     = 1'b1;
               nev.typ  = pending[i].typ;
               nev.code = pending[i].code;
               pending.delete(i);
            end
         end
         if (pop) void'(exp_q.pop_front());
         if (have) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(nev);
            else dropped = 1'b1;
         end
         if (dropped) exp_ovf = 1'b1;
         else if (ovf_clr) exp_ovf = 1'b0;
         if (exp_q.size() > 0) last_ev = exp_q[0];
      end
   end

   // Monitor: compares every presented output against the scoreboard head.
   initial begin : monitor
      logic [10:0] act_v;
      logic [10:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            exp_v = {exp_q.size() != 0, 3'(exp_q.size()), exp_q.size() == DEPTH,
                     exp_ovf, last_ev.typ, last_ev.code};
            act_v = {ev_valid, ev_count, full, overflow, ev_type, ev_code};
            checks++;
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL outputs edge=%0d {valid,count,full,ovf,type,code} got=%b required=%b",
                        edge_n, act_v, exp_v);
            end
         end
      end
   end

   task automatic drive_bg(input bit rd);
      if (rand_mode) begin
         rd_en   = ($urandom_range(0, 7) == 0);
         ovf_clr = ($urandom_range(0, 49) == 0);
      end else begin
         rd_en   = rd;
         ovf_clr = 1'b0;
      end
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         neg_tick = 1'b0;
         pos_tick = 1'b0;
         drive_bg(rd);
      end
   endtask

   // A press accepted at edge e0 and released dur cycles later.
   task automatic schedule(input int e0, input int dur, input logic [2:0] code);
      sched_t s;
      s.code = code;
      if (dur <= LONG_CYC) begin
         s.edge_no = e0 + dur;
         s.typ     = T_SHORT;
         pending.push_back(s);
      end else begin
         s.edge_no = e0 + LONG_CYC;
         s.typ     = T_LONG;
         pending.push_back(s);
         for (int e = e0 + LONG_CYC + REPEAT_CYC; e < e0 + dur; e += REPEAT_CYC) begin
            s.edge_no = e;
            s.typ     = T_REPEAT;
            pending.push_back(s);
         end
      end
   endtask

   task automatic press(input logic [2:0] code, input int dur, input int ign_at,
                        input logic [2:0] ign_code, input int rd_at);
      @(negedge clk);
      neg_tick = 1'b1;
      pos_tick = 1'b0;
      kcode    = code;
      drive_bg(1'b0);
      schedule(edge_n + 1, dur, code);
      for (int i = 1; i <= dur; i++) begin
         @(negedge clk);
         neg_tick = (i == ign_at);
         pos_tick = (i == dur);
         kcode    = (i == ign_at) ? ign_code : 3'($urandom_range(0, 4));
         drive_bg(i == rd_at);
      end
      @(negedge clk);
      neg_tick = 1'b0;
      pos_tick = 1'b0;
      drive_bg(1'b0);
   endtask

   initial begin : stimulus
      int d;
      idle(4, 1'b0);
      reset = 1'b1;

      // Short press, then a single pop
      press(3'd2, 50, 0, 3'd0, 0);
      idle(3, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b0);

      // Long hold with three repeats fills the FIFO
      press(3'd1, 165, 0, 3'd0, 0);
      idle(5, 1'b0);

      // Further hold overflows; clear, pop, then a short press fits
      press(3'd1, 125, 0, 3'd0, 0);
      idle(2, 1'b0);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      idle(1, 1'b1);
      press(3'd0, 10, 0, 3'd0, 0);
      idle(3, 1'b0);

      // Release exactly at the terminal count; stray press of key 3 ignored
      idle(4, 1'b1);
      press(3'd4, 100, 30, 3'd3, 0);
      idle(3, 1'b0);

      // Push and pop together while full
      press(3'd0, 5, 0, 3'd0, 0);
      press(3'd3, 5, 0, 3'd0, 0);
      press(3'd2, 5, 0, 3'd0, 0);
      press(3'd1, 5, 0, 3'd0, 5);
      idle(2, 1'b0);
      idle(3, 1'b1);
      idle(2, 1'b0);

      // Asynchronous reset in the middle of a press
      @(negedge clk);
      neg_tick = 1'b1;
      kcode    = 3'd1;
      idle(61, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({ev_valid, ev_code, ev_type, ev_count, full, overflow} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b required=0",
                  {ev_valid, ev_code, ev_type, ev_count, full, overflow});
      end
      idle(3, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      pos_tick = 1'b1;
      kcode    = 3'd1;
      idle(5, 1'b0);

      // Randomized presses, reads and overflow clears
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         d = int'($urandom_range(1, 200));
         press(3'($urandom_range(0, 4)), d, int'($urandom_range(0, d)),
               3'($urandom_range(0, 4)), 0);
         idle(int'($urandom_range(0, 5)), 1'b0);
      end
      rand_mode = 1'b0;
      idle(8, 1'b1);
      idle(2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
